// File: rtl/cic_decim.sv
`default_nettype none
// ============================================================================
//  Module   : cic_decim
//  Purpose  : Parametrised CIC decimation filter. ORDER registered
//             integrators run at the input rate while en is high; the
//             decimation ratio is 2^rl, chosen at run time. On each
//             decimation tick the comb chain is evaluated on the last
//             integrator and the result is left-shifted so that full scale
//             does not depend on the ratio.
//  Ports    : clk        - system clock
//             reset_n    - asynchronous active-low reset
//             en         - input-sample enable (state frozen when low)
//             in         - input sample (IN_W bits)
//             rlog2_sel  - log2 ratio; 0 or > MAX_RLOG2 selects MAX_RLOG2
//             out        - decimated, scaled output (ACC_W bits)
//             out_valid  - one-cycle pulse when out updates
//             settled    - high once the post-restart transient is flushed
//  Revision : 1.0 - initial release
// ============================================================================
module cic_decim #(
  parameter  int ORDER     = 3,
  parameter  int IN_W      = 1,
  parameter  int IN_SIGNED = 0,
  parameter  int MAX_RLOG2 = 8,
  localparam int ACC_W     = IN_W + ORDER * MAX_RLOG2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  input  logic [3:0]       rlog2_sel,
  output logic [ACC_W-1:0] out,
  output logic             out_valid,
  output logic             settled
);

  localparam int SC_W = 3;  // holds 0..ORDER+1 for ORDER <= 5

  logic [3:0]           rl_eff;
  logic [3:0]           rl_q;
  logic                 restart;
  logic [ACC_W-1:0]     x_ext;
  logic [ACC_W-1:0]     integ_q [ORDER];
  logic [ACC_W-1:0]     integ_d [ORDER];
  logic [ACC_W-1:0]     dly_q   [ORDER];
  logic [ACC_W-1:0]     dly_d   [ORDER];
  logic [ACC_W-1:0]     comb_c  [ORDER+1];
  logic [MAX_RLOG2-1:0] cnt_q, cnt_d;
  logic [MAX_RLOG2-1:0] rmask;
  logic                 tick;
  logic [SC_W-1:0]      scnt_q, scnt_d;
  logic                 settled_q, settled_d;
  logic                 valid_q, valid_d;
  logic [ACC_W-1:0]     out_q, out_d;
  logic [7:0]           shamt;

  always_comb begin
    if (rlog2_sel == 4'd0 || rlog2_sel > 4'(MAX_RLOG2)) begin
      rl_eff = 4'(MAX_RLOG2);
    end else begin
      rl_eff = rlog2_sel;
    end
  end

  // Any change of the effective ratio restarts the whole filter.
  assign restart = (rl_eff != rl_q);

  generate
    if (IN_SIGNED != 0) begin : g_sext
      assign x_ext = {{(ACC_W-IN_W){in[IN_W-1]}}, in};
    end else begin : g_zext
      assign x_ext = {{(ACC_W-IN_W){1'b0}}, in};
    end
  endgenerate

  always_comb begin
    // R-1 as a mask: low rl_q bits set.
    rmask = ~({MAX_RLOG2{1'b1}} << rl_q);
    tick  = en && !restart && (cnt_q == rmask);

    comb_c[0] = integ_q[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_c[k+1] = comb_c[k] - dly_q[k];
    end

    // Gain is 2^(ORDER*rl); shift restores the 2^(ORDER*MAX_RLOG2) scale.
    shamt = 8'(ORDER) * (8'(MAX_RLOG2) - {4'd0, rl_q});

    integ_d   = integ_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    scnt_d    = scnt_q;
    settled_d = settled_q;
    out_d     = out_q;
    valid_d   = 1'b0;

    if (restart) begin
      // Restart wins over en: the current sample is dropped. out holds.
      for (int k = 0; k < ORDER; k++) begin
        integ_d[k] = '0;
        dly_d[k]   = '0;
      end
      cnt_d     = '0;
      scnt_d    = '0;
      settled_d = 1'b0;
    end else if (en) begin
      integ_d[0] = integ_q[0] + x_ext;
      for (int k = 1; k < ORDER; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        for (int k = 0; k < ORDER; k++) begin
          dly_d[k] = comb_c[k];
        end
        out_d   = comb_c[ORDER] << shamt;
        valid_d = 1'b1;
        if (scnt_q != SC_W'(ORDER + 1)) begin
          scnt_d = scnt_q + 1'b1;
        end
        // This pulse is number scnt_q+1; settled from pulse ORDER+1 on.
        settled_d = (scnt_q >= SC_W'(ORDER));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      rl_q      <= rl_eff;
      cnt_q     <= '0;
      scnt_q    <= '0;
      settled_q <= 1'b0;
      valid_q   <= 1'b0;
      out_q     <= '0;
    end else begin
      integ_q   <= integ_d;
      dly_q     <= dly_d;
      rl_q      <= rl_eff;
      cnt_q     <= cnt_d;
      scnt_q    <= scnt_d;
      settled_q <= settled_d;
      valid_q   <= valid_d;
      out_q     <= out_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign settled   = settled_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_decim.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cic_decim
//  Purpose  : Self-checking bench for cic_decim. A default instance is
//             compared every cycle against a closed-form model (binomial
//             weighting of the input history, then an ORDER-th difference
//             of the decimated sequence). A signed 2-bit instance fed with a
//             constant -1 is checked for its full-scale settled value.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cic_decim;

  localparam int ORDER     = 3;
  localparam int MAX_RLOG2 = 8;
  localparam int ACC_W     = 1 + ORDER * MAX_RLOG2;
  localparam int ACC_S_W   = 2 + ORDER * MAX_RLOG2;

  logic               clk;
  logic               reset_n;
  logic               en;
  logic [0:0]         in_d;
  logic [1:0]         in_s;
  logic [3:0]         rlog2_sel;
  logic [ACC_W-1:0]   out;
  logic               out_valid;
  logic               settled;
  logic [ACC_S_W-1:0] out_s;
  logic               out_valid_s;
  logic               settled_s;

  cic_decim u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .in        (in_d),
    .rlog2_sel (rlog2_sel),
    .out       (out),
    .out_valid (out_valid),
    .settled   (settled)
  );

  cic_decim #(.IN_W(2), .IN_SIGNED(1)) u_dut_s (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .in        (in_s),
    .rlog2_sel (rlog2_sel),
    .out       (out_s),
    .out_valid (out_valid_s),
    .settled   (settled_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint      hist[$];   // input samples taken since reset/restart
  longint      ys[$];     // last-integrator value at each decimation tick
  int          rl_m;
  int          ncnt;
  int          pulses;
  logic [63:0] e_out;
  bit          e_valid;
  bit          e_set;
  int          cyc;

  function automatic int clampr(input int s);
    return (s == 0 || s > MAX_RLOG2) ? MAX_RLOG2 : s;
  endfunction

  function automatic longint binom(input longint n, input int k);
    longint r;
    if (n < 0 || n < k) return 0;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    ys.delete();
    ncnt    = 0;
    pulses  = 0;
    e_set   = 0;
    e_valid = 0;
    e_out   = '0;
    rl_m    = clampr(int'(rlog2_sel));
  endtask

  // Predict the effect of the coming clock edge from the applied inputs.
  task automatic model_edge();
    int     eff;
    int     n;
    longint y;
    longint c;
    eff     = clampr(int'(rlog2_sel));
    e_valid = 0;
    if (eff != rl_m) begin
      hist.delete();
      ys.delete();
      ncnt   = 0;
      pulses = 0;
      e_set  = 0;
      rl_m   = eff;
    end else if (en) begin
      ncnt++;
      if (ncnt % (1 << rl_m) == 0) begin
        // ORDER cascaded running sums of the history before this sample.
        n = hist.size();
        y = 0;
        for (int j = 0; j < n; j++) y += hist[j] * binom(longint'(n - 1 - j), ORDER - 1);
        ys.push_back(y);
        c = 0;
        for (int i = 0; i <= ORDER; i++) begin
          int idx;
          idx = ys.size() - 1 - i;
          if (idx >= 0) c += ((i % 2) ? -1 : 1) * binom(longint'(ORDER), i) * ys[idx];
        end
        e_out   = (64'(c) << (ORDER * (MAX_RLOG2 - rl_m))) & ((64'd1 << ACC_W) - 1);
        e_valid = 1;
        if (pulses < ORDER + 1) pulses++;
        e_set = (pulses >= ORDER + 1);
      end
      hist.push_back(longint'(in_d));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check("out_valid", 64'(out_valid), 64'(e_valid));
    check("out", 64'(out), e_out);
    check("settled", 64'(settled), 64'(e_set));
    check("valid_s", 64'(out_valid_s), 64'(e_valid));
    check("settled_s", 64'(settled_s), 64'(e_set));
    if (out_valid_s && settled_s) check("signed_fs", 64'(out_s), 64'h300_0000);
  endtask

  initial begin
    int first_clk;
    int last_v;
    int cnt_after;
    bit seen;

    reset_n   = 1'b1;
    en        = 1'b0;
    in_d      = '0;
    in_s      = 2'b11;
    rlog2_sel = 4'd8;
    cyc       = 0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check("rst_out", 64'(out), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_settled", 64'(settled), 64'd0);
    reset_n = 1'b1;

    // Zero input at ratio 256: first pulse in clk 257, output stays 0.
    en        = 1'b1;
    first_clk = 0;
    repeat (4 * 256 + 4) begin
      step();
      if (out_valid) begin
        if (first_clk == 0) first_clk = cyc + 1;
        check("zero_in", 64'(out), 64'd0);
      end
    end
    check("first_pulse_clk", 64'(first_clk), 64'd257);

    // Unit step at ratio 16 (restart), settled full scale 2^24.
    in_d      = 1'b1;
    rlog2_sel = 4'd4;
    repeat (16 * 8) begin
      step();
      if (out_valid && settled) check("fs_r16", 64'(out), 64'h100_0000);
    end

    // Unit input at ratio 256, then a mid-period ratio change to 64.
    rlog2_sel = 4'd8;
    repeat (256 * 5 + 100) begin
      step();
      if (out_valid && settled) check("fs_r256", 64'(out), 64'h100_0000);
    end
    rlog2_sel = 4'd6;
    step();
    check("clear_settled", 64'(settled), 64'd0);
    check("clear_valid", 64'(out_valid), 64'd0);
    cnt_after = 0;
    seen      = 0;
    while (!seen && cnt_after < 200) begin
      step();
      cnt_after++;
      if (out_valid) seen = 1;
    end
    check("restart_latency", 64'(cnt_after), 64'd64);
    repeat (64 * 5) begin
      step();
      if (out_valid && settled) check("fs_r64", 64'(out), 64'h100_0000);
    end

    // en toggling at ratio 256: pulses 512 clk apart.
    rlog2_sel = 4'd8;
    last_v    = -1;
    repeat (512 * 5 + 8) begin
      en = cyc[0];
      step();
      if (out_valid) begin
        if (last_v >= 0) check("toggle_spacing", 64'(cyc - last_v), 64'd512);
        last_v = cyc;
        if (settled) check("fs_toggle", 64'(out), 64'h100_0000);
      end
    end

    // Random enable, input and occasional ratio changes.
    repeat (6000) begin
      en   = ($urandom_range(0, 3) != 0);
      in_d = 1'($urandom);
      if ($urandom_range(0, 399) == 0) rlog2_sel = 4'($urandom_range(0, 15));
      step();
    end

    // Asynchronous reset in the middle of a period.
    rlog2_sel = 4'd3;
    repeat (37) begin
      en   = 1'b1;
      in_d = 1'($urandom);
      step();
    end
    reset_n = 1'b0;
    #1;
    check("async_out", 64'(out), 64'd0);
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_settled", 64'(settled), 64'd0);
    check("async_out_s", 64'(out_s), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (600) begin
      en   = ($urandom_range(0, 1) != 0);
      in_d = 1'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
